// File: rtl/ram32_ctrl_pkg.sv
// Shared types and constants for the RAM32 sequencer/arbiter.
package ram32_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, the port not granted last wins a tie.
// No backpressure of its own; last_grant only advances when the caller takes the grant.
module rr_arb2
    import ram32_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant_q == PORT_A) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (take && (grant != 2'b00)) begin
            last_grant_d = grant[1] ? PORT_B : PORT_A;
        end
    end

    // Starting at B lets A win the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram32_arbiter.sv
// RAM32 front end: zeroes memory after reset/clr, then serves ports A/B; ack 2 cycles after the req sample.
// Requesters hold req until ack; INIT stalls requests, one RAM access per 2 cycles at most.
module ram32_arbiter
    import ram32_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              clr_pend_q, clr_pend_d;
    logic              sel_q, sel_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic [1:0]        elig, grant;
    logic              clr_go, take;
    logic [DATA_W-1:0] acc_data;

    // A port in its ack cycle is masked so a still-held req is not served twice.
    assign elig     = {b_req & ~b_ack_q, a_req & ~a_ack_q};
    assign clr_go   = clr | clr_pend_q;
    assign take     = (state_q == ST_IDLE) & ~clr_go;
    assign acc_data = lat_we_q ? lat_wdata_q : ram_dout;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (elig),
        .take  (take),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        clr_pend_d  = clr_pend_q;
        sel_d       = sel_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        case (state_q)
            ST_INIT: begin
                if (clr) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == LAST_IDX) begin
                    init_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_go) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                    clr_pend_d = 1'b0;
                end else if (grant != 2'b00) begin
                    state_d     = ST_ACCESS;
                    sel_d       = grant[1] ? PORT_B : PORT_A;
                    lat_we_d    = grant[1] ? b_we    : a_we;
                    lat_addr_d  = grant[1] ? b_addr  : a_addr;
                    lat_wdata_d = grant[1] ? b_wdata : a_wdata;
                end
            end
            ST_ACCESS: begin
                if (clr) begin
                    clr_pend_d = 1'b1;
                end
                state_d = ST_IDLE;
                if (sel_q == PORT_A) begin
                    a_ack_d   = 1'b1;
                    a_rdata_d = acc_data;
                end else begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = acc_data;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // INIT is also the reset state, so its write strobe is qualified by rst_n.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            ST_INIT: begin
                ram_we   = rst_n;
                ram_addr = init_cnt_q;
            end
            ST_ACCESS: begin
                ram_we   = lat_we_q;
                ram_addr = lat_addr_q;
                ram_din  = lat_wdata_q;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q == ST_INIT);
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            clr_pend_q  <= 1'b0;
            sel_q       <= PORT_A;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            clr_pend_q  <= clr_pend_d;
            sel_q       <= sel_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

endmodule
